// File: rtl/lane_packer.sv
// Packs a stream of 8-bit lane records into a ROWS x LANES word (row-major,
// slot 0 in the LSBs) and presents it with an occupancy mask on valid/ready.
module lane_packer #(
    parameter int unsigned LANES = 4,
    parameter int unsigned ROWS  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*ROWS*LANES-1:0]     out_word,
    output logic [ROWS*LANES-1:0]       out_mask
);

    localparam int unsigned TOTAL = ROWS * LANES;
    localparam int unsigned CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [8*TOTAL-1:0] r_acc;
    logic [TOTAL-1:0]   r_amask;
    logic [CW-1:0]      r_cnt;
    logic [8*TOTAL-1:0] r_out_word;
    logic [TOTAL-1:0]   r_out_mask;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_complete;
    logic [8*TOTAL-1:0] w_merged_word;
    logic [TOTAL-1:0]   w_merged_mask;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && ((r_cnt == CW'(TOTAL - 1)) || in_last);

    // Accumulator with the incoming record dropped into slot r_cnt.
    always_comb begin
        w_merged_word = r_acc;
        w_merged_mask = r_amask;
        for (int unsigned k = 0; k < TOTAL; k++) begin
            if (r_cnt == CW'(k)) begin
                w_merged_word[8*k +: 8] = in_data;
                w_merged_mask[k]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_amask     <= '0;
            r_cnt       <= '0;
            r_out_word  <= '0;
            r_out_mask  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_complete) begin
                r_out_word  <= w_merged_word;
                r_out_mask  <= w_merged_mask;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_amask     <= '0;
                r_cnt       <= '0;
            end else begin
                if (w_accept) begin
                    r_acc   <= w_merged_word;
                    r_amask <= w_merged_mask;
                    r_cnt   <= r_cnt + CW'(1);
                end
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_mask  = r_out_mask;

endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer: directed scenarios plus randomized
// traffic against a queue-based reference model of the packing rules.
module tb_lane_packer;

    localparam int unsigned LANES = 4;
    localparam int unsigned ROWS  = 2;
    localparam int unsigned TOTAL = LANES * ROWS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [7:0]           in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [8*TOTAL-1:0]   out_word;
    logic [TOTAL-1:0]     out_mask;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic [7:0]           m_q[$];
    logic [8*TOTAL-1:0]   m_word = '0;
    logic [TOTAL-1:0]     m_mask = '0;
    bit                   m_valid = 1'b0;
    logic                 exp_ready;
    logic                 obs_ready;

    lane_packer #(.LANES(LANES), .ROWS(ROWS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_mask (out_mask)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs from a negedge, advance the model across the
    // following posedge, and return at the next negedge.
    task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic r);
        bit completed;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        obs_ready = in_ready;
        exp_ready = !m_valid || r;
        @(posedge clk);
        completed = 1'b0;
        if (v && exp_ready) begin
            m_q.push_back(d);
            if (m_q.size() == TOTAL || l) begin
                m_word = '0;
                m_mask = '0;
                foreach (m_q[j]) begin
                    m_word = m_word | ((8*TOTAL)'(m_q[j]) << (8*j));
                    m_mask[j] = 1'b1;
                end
                m_q.delete();
                m_valid = 1'b1;
                completed = 1'b1;
            end
        end
        if (!completed && m_valid && r) m_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_word  = '0;
        m_mask  = '0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_word !== '0) $display("FAIL reset_word got %h want 0", out_word); else pass_cnt++;
        total_cnt++; if (out_mask !== '0) $display("FAIL reset_mask got %h want 0", out_mask); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        logic [7:0] recs [8];
        recs = '{8'h00, 8'h31, 8'h02, 8'h33, 8'h04, 8'h35, 8'h06, 8'h37};
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, recs[i], 1'b0, 1'b1);
            total_cnt++; if (obs_ready !== 1'b1) $display("FAIL full_ready[%0d] got %b want 1", i, obs_ready); else pass_cnt++;
            if (i < 7) begin
                total_cnt++; if (out_valid !== 1'b0) $display("FAIL full_early_valid[%0d] got %b want 0", i, out_valid); else pass_cnt++;
            end
        end
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL full_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_word !== 64'h3706_3504_3302_3100) $display("FAIL full_word got %h want %h", out_word, 64'h3706_3504_3302_3100); else pass_cnt++;
        total_cnt++; if (out_word !== m_word) $display("FAIL full_word_model got %h want %h", out_word, m_word); else pass_cnt++;
        total_cnt++; if (out_mask !== 8'hFF) $display("FAIL full_mask got %h want ff", out_mask); else pass_cnt++;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL full_retire got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_partial();
        tick(1'b1, 8'hA1, 1'b0, 1'b1);
        tick(1'b1, 8'hB2, 1'b0, 1'b1);
        tick(1'b1, 8'hC3, 1'b1, 1'b1);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL partial_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_word !== 64'h0000_0000_00C3_B2A1) $display("FAIL partial_word got %h want 00c3b2a1", out_word); else pass_cnt++;
        total_cnt++; if (out_mask !== 8'h07) $display("FAIL partial_mask got %h want 07", out_mask); else pass_cnt++;
        tick(1'b1, 8'h11, 1'b0, 1'b1);
        tick(1'b1, 8'h22, 1'b1, 1'b1);
        total_cnt++; if (out_word !== 64'h2211) $display("FAIL partial_next_word got %h want 2211", out_word); else pass_cnt++;
        total_cnt++; if (out_mask !== 8'h03) $display("FAIL partial_next_mask got %h want 03", out_mask); else pass_cnt++;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [8*TOTAL-1:0] held;
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        held = out_word;
        total_cnt++; if (out_word !== 64'h4746_4544_4342_4140) $display("FAIL bp_word got %h want 4746454443424140", out_word); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'hEE, 1'b0, 1'b0);
            total_cnt++; if (obs_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, obs_ready); else pass_cnt++;
            total_cnt++; if (out_valid !== 1'b1 || out_word !== held) $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, out_valid, out_word, held); else pass_cnt++;
        end
        // Retire and load on the same edge: out_valid must not drop.
        tick(1'b1, 8'h99, 1'b1, 1'b1);
        total_cnt++; if (obs_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", obs_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_nobubble got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_word !== 64'h99 || out_mask !== 8'h01) $display("FAIL bp_new_word got %h/%h want 99/01", out_word, out_mask); else pass_cnt++;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int words = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'($urandom), 1'b0, 1'b1);
            total_cnt++; if (out_valid !== m_valid) $display("FAIL b2b_valid[%0d] got %b want %b", i, out_valid, m_valid); else pass_cnt++;
            if (m_valid) begin
                words++;
                total_cnt++; if (out_word !== m_word || out_mask !== 8'hFF) $display("FAIL b2b_word[%0d] got %h/%h want %h/ff", i, out_word, out_mask, m_word); else pass_cnt++;
            end
        end
        total_cnt++; if (words != 2) $display("FAIL b2b_count got %0d want 2", words); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'(8'hC0 + i), 1'b1, 1'b1);
            total_cnt++; if (out_valid !== 1'b1 || out_word !== 64'(8'hC0 + i)) $display("FAIL b2b_single[%0d] got %b/%h want 1/%h", i, out_valid, out_word, 8'hC0 + i); else pass_cnt++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
        tick(1'b1, 8'hD5, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || out_word !== '0 || out_mask !== '0) $display("FAIL midrst_outputs got %b/%h/%h want 0/0/0", out_valid, out_word, out_mask); else pass_cnt++;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
        total_cnt++; if (out_valid !== 1'b1 || out_word !== 64'h7776_7574_7372_7170) $display("FAIL midrst_word got %b/%h want 1/7776757473727170", out_valid, out_word); else pass_cnt++;
        total_cnt++; if (out_mask !== 8'hFF) $display("FAIL midrst_mask got %h want ff", out_mask); else pass_cnt++;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_single();
        tick(1'b1, 8'h5A, 1'b1, 1'b1);
        total_cnt++; if (out_valid !== 1'b1 || out_word !== 64'h5A) $display("FAIL single_word got %b/%h want 1/5a", out_valid, out_word); else pass_cnt++;
        total_cnt++; if (out_mask !== 8'h01) $display("FAIL single_mask got %h want 01", out_mask); else pass_cnt++;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
            total_cnt++;
            if (obs_ready !== exp_ready) begin
                $display("FAIL rand_ready[%0d] got %b want %b", i, obs_ready, exp_ready);
            end else pass_cnt++;
            total_cnt++;
            if (out_valid !== m_valid) begin
                $display("FAIL rand_valid[%0d] got %b want %b", i, out_valid, m_valid);
            end else pass_cnt++;
            if (m_valid) begin
                total_cnt++;
                if (out_word !== m_word || out_mask !== m_mask)
                    $display("FAIL rand_word[%0d] got %h/%h want %h/%h", i, out_word, out_mask, m_word, m_mask);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_single();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
